uart_rx_buffered: RTL

UART_RX_BUFFERED -- requirements
Module: uart_rx_buffered

---
 rtl/uart_rx_buffered.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/uart_rx_buffered.sv
// 8N1 UART receiver with mid-bit sampling and a first-word-fall-through receive FIFO.
// Good bytes are pushed at the stop sample; overrun and framing errors are reported as single-cycle pulses.
module uart_rx_buffered #(
   parameter int CLK_FREQ   = 50000000,
   parameter int BAUD       = 9600,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          rxd,
   output logic [7:0]                    rx_data,
   output logic                          rx_valid,
   input  logic                          rx_ready,
   output logic                          rx_overrun,
   output logic                          rx_frame_err,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic [2:0]                    o_dbg_state
);

   localparam int DIV  = CLK_FREQ / BAUD;
   localparam int HALF = DIV / 2;
   localparam int CW   = $clog2(DIV);
   localparam int PW   = $clog2(FIFO_DEPTH);

   if (DIV < 4) begin : g_div_check
      $error("uart_rx_buffered: CLK_FREQ/BAUD must be at least 4");
   end
   if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_depth_check
      $error("uart_rx_buffered: FIFO_DEPTH must be a power of 2 and at least 2");
   end

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      START     = 3'd1,
      DATA      = 3'd2,
      STOP      = 3'd3,
      WAIT_HIGH = 3'd4
   } state_t;

   state_t          r_state;
   state_t          w_next;
   logic            r_sync1;
   logic            r_sync2;
   logic [CW-1:0]   r_cnt;
   logic [2:0]      r_idx;
   logic [7:0]      r_shift;
   logic [7:0]      r_mem [FIFO_DEPTH];
   logic [PW-1:0]   r_wptr;
   logic [PW-1:0]   r_rptr;
   logic [PW:0]     r_count;
   logic            r_overrun;
   logic            r_frame_err;

   logic            w_rxs;
   logic            w_tick;
   logic            w_full;
   logic            w_pop;
   logic            w_push;
   logic            w_drop;
   logic            w_ferr;

   assign w_rxs  = r_sync2;
   assign w_tick = (r_cnt == '0);
   assign w_full = (r_count == (PW+1)'(FIFO_DEPTH));
   assign w_pop  = rx_ready && (r_count != '0);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_sync1 <= 1'b1;
         r_sync2 <= 1'b1;
      end else begin
         r_sync1 <= rxd;
         r_sync2 <= r_sync1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      w_push = 1'b0;
      w_drop = 1'b0;
      w_ferr = 1'b0;
      case (r_state)
         IDLE: begin
            if (!w_rxs) w_next = START;
         end
         START: begin
            if (w_tick) w_next = w_rxs ? IDLE : DATA;
         end
         DATA: begin
            if (w_tick && (r_idx == 3'd7)) w_next = STOP;
         end
         STOP: begin
            if (w_tick) begin
               if (w_rxs) begin
                  // A pop in the same cycle frees a slot, so a full FIFO can still accept.
                  if (!w_full || w_pop) w_push = 1'b1;
                  else                  w_drop = 1'b1;
                  w_next = IDLE;
               end else begin
                  w_ferr = 1'b1;
                  w_next = WAIT_HIGH;
               end
            end
         end
         WAIT_HIGH: begin
            if (w_rxs) w_next = IDLE;
         end
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt   <= '0;
         r_idx   <= '0;
         r_shift <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (!w_rxs) r_cnt <= CW'(HALF - 1);
            end
            START, DATA, STOP: begin
               r_cnt <= w_tick ? CW'(DIV - 1) : r_cnt - CW'(1);
            end
            default: ;
         endcase
         if ((r_state == START) && w_tick) r_idx <= '0;
         if ((r_state == DATA) && w_tick) begin
            r_shift[r_idx] <= w_rxs;
            r_idx          <= r_idx + 3'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wptr] <= r_shift;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wptr      <= '0;
         r_rptr      <= '0;
         r_count     <= '0;
         r_overrun   <= 1'b0;
         r_frame_err <= 1'b0;
      end else begin
         if (w_push) r_wptr <= r_wptr + PW'(1);
         if (w_pop)  r_rptr <= r_rptr + PW'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + (PW+1)'(1);
            2'b01:   r_count <= r_count - (PW+1)'(1);
            default: r_count <= r_count;
         endcase
         r_overrun   <= w_drop;
         r_frame_err <= w_ferr;
      end
   end

   // Head byte is masked while empty so the output reads zero out of reset.
   assign rx_data      = (r_count != '0) ? r_mem[r_rptr] : 8'h00;
   assign rx_valid     = (r_count != '0);
   assign rx_overrun   = r_overrun;
   assign rx_frame_err = r_frame_err;
   assign fifo_count   = r_count;
   assign o_dbg_state  = r_state;

endmodule
